// File: rtl/udp_img_line_pkt.sv
// udp_img_line_pkt: buffers pixel words in a FIFO and emits them as UDP packets
// of LINES_PER_PKT lines. Each packet starts with a frame marker and a
// {frame id, first line} word, so the host can place packets independently.
module udp_img_line_pkt #(
  parameter int unsigned H_WORDS       = 640,
  parameter int unsigned V_LINES       = 480,
  parameter int unsigned LINES_PER_PKT = 1,
  parameter int unsigned FIFO_AW       = 11,
  parameter logic [31:0] FRAME_HEAD    = 32'hF05AA50F
) (
  input  logic        eth_tx_clk,
  input  logic        rst_n,
  input  logic        transfer_flag,
  input  logic        img_frame_start,
  input  logic        img_data_en,
  input  logic [31:0] img_data,
  input  logic        udp_tx_req,
  input  logic        udp_tx_done,
  output logic        udp_tx_start_en,
  output logic [31:0] udp_tx_data,
  output logic [15:0] udp_tx_byte_num,
  output logic [15:0] frame_cnt,
  output logic        ovf_flag
);

  localparam int unsigned PKT_PIX   = LINES_PER_PKT * H_WORDS;
  localparam int unsigned PKT_WORDS = PKT_PIX + 2;
  localparam int unsigned TOTAL     = H_WORDS * V_LINES;
  localparam int unsigned DEPTH     = 1 << FIFO_AW;
  localparam int          WCW       = $clog2(TOTAL + 1);
  localparam int          RCW       = $clog2(PKT_WORDS + 1);
  localparam int          CW        = FIFO_AW + 1;

  localparam logic [15:0]    BYTE_NUM  = 16'(PKT_WORDS * 4);
  localparam logic [CW-1:0]  THRESH    = CW'(PKT_PIX);
  localparam logic [CW-1:0]  FULL_CNT  = CW'(DEPTH);
  localparam logic [WCW-1:0] TOTAL_W   = WCW'(TOTAL);
  localparam logic [RCW-1:0] LAST_REQ  = RCW'(PKT_WORDS - 1);
  localparam logic [15:0]    LPP_16    = 16'(LINES_PER_PKT);
  localparam logic [15:0]    V_16      = 16'(V_LINES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_START,
    S_SEND,
    S_WAIT_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [RCW-1:0]       req_cnt_q, req_cnt_d;
  logic [15:0]          line_idx_q, line_idx_d;
  logic [31:0]          data_q, data_d;
  logic                 armed_q, armed_d;
  logic                 started_q, started_d;
  logic [WCW-1:0]       wr_cnt_q, wr_cnt_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;
  logic                 ovf_q, ovf_d;
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_addr;
  logic [CW-1:0]        fifo_cnt_q, fifo_cnt_d;
  logic [31:0]          mem_q [DEPTH];
  logic                 flush, wr_en, pop;

  // A dropped transfer_flag or a new frame start empties the FIFO immediately.
  assign flush = ~transfer_flag | img_frame_start;

  // Write side: frame arming, frame id, word budget and overflow detection.
  always_comb begin
    armed_d     = armed_q;
    started_d   = started_q;
    wr_cnt_d    = wr_cnt_q;
    frame_cnt_d = frame_cnt_q;
    ovf_d       = ovf_q;
    wr_en       = 1'b0;
    if (!transfer_flag) begin
      armed_d = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      if (img_frame_start) begin
        armed_d   = 1'b1;
        wr_cnt_d  = '0;
        started_d = 1'b1;
        if (started_q) frame_cnt_d = frame_cnt_q + 16'd1;
      end
      if (armed_d && img_data_en && (wr_cnt_d < TOTAL_W)) begin
        wr_cnt_d = wr_cnt_d + WCW'(1);
        if (!img_frame_start && (fifo_cnt_q == FULL_CNT)) ovf_d = 1'b1;
        else                                               wr_en = 1'b1;
      end
    end
  end

  // Read FSM: waits for a full packet's worth of words, then serves reqs.
  always_comb begin
    state_d    = state_q;
    req_cnt_d  = req_cnt_q;
    line_idx_d = line_idx_q;
    data_d     = data_q;
    pop        = 1'b0;
    if (!transfer_flag) begin
      state_d    = S_IDLE;
      req_cnt_d  = '0;
      line_idx_d = '0;
      data_d     = '0;
    end else if (img_frame_start) begin
      state_d    = S_WAIT;
      req_cnt_d  = '0;
      line_idx_d = '0;
      if (udp_tx_req) data_d = '0;
    end else begin
      if (udp_tx_req) data_d = '0;
      case (state_q)
        S_IDLE: ;
        S_WAIT: begin
          if (fifo_cnt_q >= THRESH) state_d = S_START;
        end
        S_START: begin
          req_cnt_d = '0;
          state_d   = S_SEND;
        end
        S_SEND: begin
          if (udp_tx_req) begin
            if (req_cnt_q == RCW'(0)) begin
              data_d = FRAME_HEAD;
            end else if (req_cnt_q == RCW'(1)) begin
              data_d = {frame_cnt_q, line_idx_q};
            end else begin
              data_d = mem_q[rd_ptr_q];
              pop    = (fifo_cnt_q != '0);
            end
            req_cnt_d = req_cnt_q + RCW'(1);
            if (req_cnt_q == LAST_REQ) state_d = S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (udp_tx_done) begin
            line_idx_d = line_idx_q + LPP_16;
            state_d    = (line_idx_d >= V_16) ? S_IDLE : S_WAIT;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy; a flush lands before any same-cycle write.
  always_comb begin
    wr_ptr_d   = flush ? '0 : wr_ptr_q;
    rd_ptr_d   = flush ? '0 : rd_ptr_q;
    fifo_cnt_d = flush ? '0 : fifo_cnt_q;
    wr_addr    = wr_ptr_d;
    if (wr_en) wr_ptr_d = wr_ptr_d + FIFO_AW'(1);
    if (pop)   rd_ptr_d = rd_ptr_d + FIFO_AW'(1);
    case ({wr_en, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_d + CW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_d - CW'(1);
      default: fifo_cnt_d = fifo_cnt_d;
    endcase
  end

  // FIFO storage has no reset; occupancy alone decides what is valid.
  always_ff @(posedge eth_tx_clk) begin
    if (wr_en) mem_q[wr_addr] <= img_data;
  end

  // State registers for both the write side and the read FSM.
  always_ff @(posedge eth_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_cnt_q   <= '0;
      line_idx_q  <= '0;
      data_q      <= '0;
      armed_q     <= 1'b0;
      started_q   <= 1'b0;
      wr_cnt_q    <= '0;
      frame_cnt_q <= '0;
      ovf_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_cnt_q   <= req_cnt_d;
      line_idx_q  <= line_idx_d;
      data_q      <= data_d;
      armed_q     <= armed_d;
      started_q   <= started_d;
      wr_cnt_q    <= wr_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      ovf_q       <= ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
    end
  end

  // The start pulse is suppressed in any cycle that abandons the packet.
  assign udp_tx_start_en = (state_q == S_START) & transfer_flag & ~img_frame_start;
  assign udp_tx_data     = data_q;
  assign udp_tx_byte_num = BYTE_NUM;
  assign frame_cnt       = frame_cnt_q;
  assign ovf_flag        = ovf_q;

endmodule

// File: doc/udp_img_line_pkt.md
# udp_img_line_pkt

Single-clock, parametrised image-to-UDP packetiser. Pixel words already in the Ethernet transmit domain are buffered in an internal synchronous FIFO. The block cuts each frame into fixed-size packets of `LINES_PER_PKT` lines. Every packet gets a two-word header (frame marker, then frame id and line index), so the host can place each packet even when earlier packets were lost. It sits between the frame-buffer read path and the UDP transmit core, and replaces the per-frame, header-once packetiser.

## Interface
Parameters:
- `H_WORDS`, 640: 32-bit data words per image line.
- `V_LINES`, 480: lines per frame.
- `LINES_PER_PKT`, 1: lines per UDP packet; must divide `V_LINES`.
- `FIFO_AW`, 11: FIFO address width; depth = 2^`FIFO_AW` words. Must hold at least `LINES_PER_PKT`*`H_WORDS` words.
- `FRAME_HEAD`, 32'hF05AA50F: header word 0.

Ports (one clock domain, `eth_tx_clk`; reset is asynchronous, active-low `rst_n`):
- `eth_tx_clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `transfer_flag`  in  1  1 = streaming enabled; 0 = flush and idle.
- `img_frame_start`  in  1  one-cycle pulse before or with the first word of a frame.
- `img_data_en`  in  1  `img_data` valid this cycle.
- `img_data`  in  32  pixel word.
- `udp_tx_req`  in  1  UDP core requests the next payload word.
- `udp_tx_done`  in  1  one-cycle pulse: packet fully transmitted.
- `udp_tx_start_en`  out  1  one-cycle pulse: start a packet.
- `udp_tx_data`  out  32  payload word, registered.
- `udp_tx_byte_num`  out  16  packet payload length in bytes.
- `frame_cnt`  out  16  id of the current frame.
- `ovf_flag`  out  1  sticky: a word was dropped on a full FIFO.

## Operation
- PKT_WORDS = 2 + `LINES_PER_PKT`*`H_WORDS`. `udp_tx_byte_num` is the constant PKT_WORDS*4, truncated to 16 bits; parameters are chosen so it does not overflow.
- Write side:
  - `img_frame_start` with `transfer_flag`=1 arms the frame. It clears the write word counter, flushes the FIFO and returns the FSM to WAIT.
  - `frame_cnt` increments on every accepted start, wrapping at 16 bits. The first frame after reset is 0.
  - While armed, each `img_data_en` writes `img_data` to the FIFO. Writing stops after `H_WORDS`*`V_LINES` words; surplus words are ignored.
  - A write attempted while the FIFO is full is dropped and sets `ovf_flag`.
- Read FSM states:
  - IDLE: no frame armed.
  - WAIT: moves to START when FIFO count ≥ `LINES_PER_PKT`*`H_WORDS`.
  - START: asserts `udp_tx_start_en` for one cycle, then goes to SEND.
  - SEND: counts `udp_tx_req` pulses and moves to WAIT_DONE after PKT_WORDS of them.
    - req 1 → `FRAME_HEAD`.
    - req 2 → {`frame_cnt`, line_idx}, where line_idx is the first line of this packet.
    - req 3..PKT_WORDS → FIFO pops.
  - WAIT_DONE: on `udp_tx_done`, line_idx += `LINES_PER_PKT`. Returns to WAIT, or to IDLE once line_idx reaches `V_LINES`.
- `udp_tx_req` outside SEND is ignored, and `udp_tx_data` stays 0. `udp_tx_done` outside WAIT_DONE is ignored.
- `transfer_flag`=0, in any state: FIFO flushed, FSM to IDLE, write side disarmed, `udp_tx_start_en`=0, `udp_tx_data`=0, `ovf_flag` cleared. `frame_cnt` is held.
- `img_frame_start` mid-frame, in any FSM state: the current frame is abandoned and the new frame is armed at once. Any packet in SEND or WAIT_DONE is abandoned, and its remaining reqs return 0.
- `img_frame_start` and `img_data_en` in the same cycle: the word is the new frame's first word.

## Timing
- Reset values: `udp_tx_start_en`=0, `udp_tx_data`=0, `udp_tx_byte_num`=PKT_WORDS*4, `frame_cnt`=0, `ovf_flag`=0, FSM in IDLE, FIFO empty.
- FIFO write-to-count visibility: 1 cycle.
- `udp_tx_start_en` asserts 2 cycles after the write that reaches the threshold: 1 cycle count update, then the WAIT→START register.
- Read latency: `udp_tx_data` is valid the cycle after `udp_tx_req`. It holds its value until the next req.
- A simultaneous FIFO write and pop in the same cycle leaves the count unchanged.
- The frame-start flush takes effect in the same cycle as the pulse. Words offered in that cycle are written after the flush.

## Test plan
- Params `H_WORDS`=4, `V_LINES`=3, `LINES_PER_PKT`=1, `frame_cnt`=0:
  - Stimulus: start pulse, then 12 words 0x1..0xC; UDP core issues req bursts of 6 words, each followed by done.
  - Response: 3 start pulses, `udp_tx_byte_num`=24.
  - Payloads: {F05AA50F, 00000000, 1, 2, 3, 4}, {F05AA50F, 00000001, 5..8}, {F05AA50F, 00000002, 9..C}. FSM then returns to IDLE.
- Same parameters, second frame:
  - Response: header word 1 of the first packet = 0x00010000. After 65536 frames `frame_cnt` wraps to 0.
- `LINES_PER_PKT`=3:
  - Response: one packet, byte_num=56, 14 words.
- `FIFO_AW`=2 (depth 4), no reqs issued, 6 words written:
  - Response: words 5 and 6 dropped, `ovf_flag`=1.
  - `ovf_flag` clears only when `transfer_flag`=0.
- `transfer_flag` dropped in SEND after 3 reqs:
  - Response: FSM to IDLE, further reqs return 0, no new start until the next `img_frame_start` with `transfer_flag`=1.
- New `img_frame_start` after 2 of 3 lines:
  - Response: next packet carries `frame_cnt`+1 and line_idx 0. Old-frame words are never sent.
